// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage ALU: operation encodings and the
// multiply/divide engine state type.
package alu_pkg;

  localparam logic [3:0] OP_AND  = 4'b0000;
  localparam logic [3:0] OP_OR   = 4'b0001;
  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_XOR  = 4'b0011;
  localparam logic [3:0] OP_NOR  = 4'b0100;
  localparam logic [3:0] OP_SLL  = 4'b0101;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_SLT  = 4'b0111;
  localparam logic [3:0] OP_SLTU = 4'b1000;
  localparam logic [3:0] OP_SRL  = 4'b1001;
  localparam logic [3:0] OP_SRA  = 4'b1010;
  localparam logic [3:0] OP_MULT = 4'b1011;
  localparam logic [3:0] OP_DIV  = 4'b1100;
  localparam logic [3:0] OP_DIVU = 4'b1101;
  localparam logic [3:0] OP_MFHI = 4'b1110;
  localparam logic [3:0] OP_MFLO = 4'b1111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } md_state_e;

endpackage

// File: rtl/md_unit.sv
// Iterative background multiply/divide engine: shift-add multiply, restoring
// divide on operand magnitudes, sign fix-up in FIX, architectural HI/LO.
module md_unit
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] src_a,
  input  logic [WIDTH-1:0] src_b,
  input  logic [3:0]       op,
  input  logic             valid,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             idle
);

  md_state_e state, next_state;
  logic [SHW-1:0]     cnt;
  logic               is_div, neg_lo, neg_hi, div_zero;
  logic [WIDTH-1:0]   opnd;
  logic [2*WIDTH-1:0] acc, acc_next, prod_fix;
  logic               issue, last_iter, signed_op, neg_a, neg_b, div_ge;
  logic [WIDTH-1:0]   mag_a, mag_b, div_rem, hi_fix, lo_fix;
  logic [WIDTH:0]     mul_sum;

  assign issue     = valid && (op == OP_MULT || op == OP_DIV || op == OP_DIVU) && (state == IDLE);
  assign signed_op = (op == OP_MULT) || (op == OP_DIV);
  assign neg_a     = signed_op & src_a[WIDTH-1];
  assign neg_b     = signed_op & src_b[WIDTH-1];
  assign mag_a     = neg_a ? -src_a : src_a;
  assign mag_b     = neg_b ? -src_b : src_b;
  assign last_iter = (cnt == {SHW{1'b1}});
  assign idle      = (state == IDLE);

  // acc holds {partial product, multiplier} or {remainder, dividend/quotient}
  assign mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opnd};
  assign div_ge  = acc[2*WIDTH-1:WIDTH-1] >= {1'b0, opnd};
  assign div_rem = acc[2*WIDTH-2:WIDTH-1] - opnd;

  // One multiply or divide iteration
  always_comb begin
    acc_next = acc;
    if (is_div) begin
      if (div_ge) acc_next = {div_rem, acc[WIDTH-2:0], 1'b1};
      else        acc_next = {acc[2*WIDTH-2:0], 1'b0};
    end else begin
      if (acc[0]) acc_next = {mul_sum, acc[WIDTH-1:1]};
      else        acc_next = {1'b0, acc[2*WIDTH-1:1]};
    end
  end

  // Sign fix-up; divide-by-zero forces an all-ones quotient
  always_comb begin
    prod_fix = neg_lo ? -acc : acc;
    hi_fix   = prod_fix[2*WIDTH-1:WIDTH];
    lo_fix   = prod_fix[WIDTH-1:0];
    if (is_div) begin
      hi_fix = neg_hi ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      if (div_zero) lo_fix = {WIDTH{1'b1}};
      else          lo_fix = neg_lo ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    end else begin
      hi_fix = prod_fix[2*WIDTH-1:WIDTH];
    end
  end

  // Engine state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Engine next-state logic
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (issue) next_state = CALC; else next_state = IDLE;
      CALC:    if (last_iter) next_state = FIX; else next_state = CALC;
      FIX:     next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Operand latch, iteration datapath, counter and HI/LO
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= {SHW{1'b0}};
      acc      <= {(2*WIDTH){1'b0}};
      opnd     <= {WIDTH{1'b0}};
      is_div   <= 1'b0;
      neg_lo   <= 1'b0;
      neg_hi   <= 1'b0;
      div_zero <= 1'b0;
      hi       <= {WIDTH{1'b0}};
      lo       <= {WIDTH{1'b0}};
    end else begin
      case (state)
        IDLE: begin
          if (issue) begin
            acc      <= {{WIDTH{1'b0}}, mag_a};
            opnd     <= mag_b;
            is_div   <= (op != OP_MULT);
            neg_lo   <= neg_a ^ neg_b;
            neg_hi   <= neg_a;
            div_zero <= (src_b == {WIDTH{1'b0}});
            cnt      <= {SHW{1'b0}};
          end
        end
        CALC: begin
          acc <= acc_next;
          cnt <= cnt + {{(SHW-1){1'b0}}, 1'b1};
        end
        FIX: begin
          hi <= hi_fix;
          lo <= lo_fix;
        end
        default: cnt <= {SHW{1'b0}};
      endcase
    end
  end

endmodule

// File: rtl/alu_muldiv.sv
// Execute-stage ALU: combinational single-cycle ops and flags, HI/LO reads,
// and the stall request for the background multiply/divide engine.
module alu_muldiv
  import alu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] SrcAE,
  input  logic [WIDTH-1:0] SrcBE,
  input  logic [3:0]       ALUControlE,
  input  logic             ValidE,
  output logic [WIDTH-1:0] ALUOutE,
  output logic             ZeroE,
  output logic             OverflowE,
  output logic             BusyE
);

  logic [WIDTH-1:0] hi, lo, sum, diff;
  logic [SHW-1:0]   shamt;
  logic             md_idle, uses_md;

  md_unit #(.WIDTH(WIDTH)) u_md (
    .clk   (clk),
    .rst_n (rst_n),
    .src_a (SrcAE),
    .src_b (SrcBE),
    .op    (ALUControlE),
    .valid (ValidE),
    .hi    (hi),
    .lo    (lo),
    .idle  (md_idle)
  );

  assign sum   = SrcAE + SrcBE;
  assign diff  = SrcAE - SrcBE;
  assign shamt = SrcBE[SHW-1:0];

  // Op-code 1011 and above all touch the engine or HI/LO
  assign uses_md = (ALUControlE >= OP_MULT);
  assign BusyE   = ValidE & uses_md & ~md_idle;
  assign ZeroE   = (ALUOutE == {WIDTH{1'b0}});

  // Result mux and signed overflow
  always_comb begin
    ALUOutE   = {WIDTH{1'b0}};
    OverflowE = 1'b0;
    case (ALUControlE)
      OP_AND:  ALUOutE = SrcAE & SrcBE;
      OP_OR:   ALUOutE = SrcAE | SrcBE;
      OP_ADD: begin
        ALUOutE   = sum;
        OverflowE = (SrcAE[WIDTH-1] == SrcBE[WIDTH-1]) && (sum[WIDTH-1] != SrcAE[WIDTH-1]);
      end
      OP_XOR:  ALUOutE = SrcAE ^ SrcBE;
      OP_NOR:  ALUOutE = ~(SrcAE | SrcBE);
      OP_SLL:  ALUOutE = SrcAE << shamt;
      OP_SUB: begin
        ALUOutE   = diff;
        OverflowE = (SrcAE[WIDTH-1] != SrcBE[WIDTH-1]) && (diff[WIDTH-1] != SrcAE[WIDTH-1]);
      end
      OP_SLT:  ALUOutE = {{(WIDTH-1){1'b0}}, ($signed(SrcAE) < $signed(SrcBE))};
      OP_SLTU: ALUOutE = {{(WIDTH-1){1'b0}}, (SrcAE < SrcBE)};
      OP_SRL:  ALUOutE = SrcAE >> shamt;
      OP_SRA:  ALUOutE = $signed(SrcAE) >>> shamt;
      OP_MFHI: ALUOutE = hi;
      OP_MFLO: ALUOutE = lo;
      default: ALUOutE = {WIDTH{1'b0}};
    endcase
  end

endmodule

// File: tb/tb_alu_muldiv.sv
// Scoreboard bench for alu_muldiv: directed vectors push expectations, a
// negedge monitor pops and compares on every valid EX cycle.
module tb_alu_muldiv;

  localparam logic [3:0] C_AND = 4'b0000, C_OR = 4'b0001, C_ADD = 4'b0010, C_XOR = 4'b0011;
  localparam logic [3:0] C_NOR = 4'b0100, C_SLL = 4'b0101, C_SUB = 4'b0110, C_SLT = 4'b0111;
  localparam logic [3:0] C_SLTU = 4'b1000, C_SRL = 4'b1001, C_SRA = 4'b1010, C_MULT = 4'b1011;
  localparam logic [3:0] C_DIV = 4'b1100, C_DIVU = 4'b1101, C_MFHI = 4'b1110, C_MFLO = 4'b1111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] SrcAE, SrcBE, ALUOutE;
  logic [3:0]  ALUControlE;
  logic        ValidE, ZeroE, OverflowE, BusyE;

  typedef struct {
    string       name;
    logic [31:0] out;
    logic        ovf;
    logic        busy;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  alu_muldiv #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .SrcAE       (SrcAE),
    .SrcBE       (SrcBE),
    .ALUControlE (ALUControlE),
    .ValidE      (ValidE),
    .ALUOutE     (ALUOutE),
    .ZeroE       (ZeroE),
    .OverflowE   (OverflowE),
    .BusyE       (BusyE)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n && ValidE) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_cycle: out=%h busy=%b, no expectation queued", ALUOutE, BusyE);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (ALUOutE !== e.out || ZeroE !== (e.out == 32'h0) || OverflowE !== e.ovf || BusyE !== e.busy) begin
          errors++;
          $display("FAIL %s: got out=%h zero=%b ovf=%b busy=%b, want out=%h zero=%b ovf=%b busy=%b",
                   e.name, ALUOutE, ZeroE, OverflowE, BusyE, e.out, (e.out == 32'h0), e.ovf, e.busy);
        end
      end
    end
  end

  task automatic drive(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input string nm, input logic [31:0] out, input logic ovf, input logic busy);
    exp_t e;
    ALUControlE = op;
    SrcAE       = a;
    SrcBE       = b;
    ValidE      = 1'b1;
    e.name = nm; e.out = out; e.ovf = ovf; e.busy = busy;
    sb.push_back(e);
    @(posedge clk);
    #1;
  endtask

  task automatic bubble(input int n);
    ValidE = 1'b0;
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic read_stall(input logic [3:0] op, input string nm, input int n_busy,
                            input logic [31:0] old_v, input logic [31:0] new_v);
    for (int i = 0; i < n_busy; i++) drive(op, 32'h0, 32'h0, {nm, "_stall"}, old_v, 1'b0, 1'b1);
    drive(op, 32'h0, 32'h0, nm, new_v, 1'b0, 1'b0);
  endtask

  task automatic md_stall_issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                input string nm, input int n_busy);
    for (int i = 0; i < n_busy; i++) drive(op, a, b, {nm, "_stall"}, 32'h0, 1'b0, 1'b1);
    drive(op, a, b, nm, 32'h0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n = 1'b0; ValidE = 1'b0; SrcAE = 32'h0; SrcBE = 32'h0; ALUControlE = 4'h0;
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;

    drive(C_MFHI, 32'h0, 32'h0, "reset_hi", 32'h0, 1'b0, 1'b0);
    drive(C_MFLO, 32'h0, 32'h0, "reset_lo", 32'h0, 1'b0, 1'b0);

    drive(C_ADD,  32'h7FFFFFFF, 32'h1,        "add_ovf",  32'h80000000, 1'b1, 1'b0);
    drive(C_ADD,  32'hFFFFFFFF, 32'h1,        "add_wrap", 32'h00000000, 1'b0, 1'b0);
    drive(C_SUB,  32'h5,        32'h5,        "sub_zero", 32'h00000000, 1'b0, 1'b0);
    drive(C_SUB,  32'h80000000, 32'h1,        "sub_ovf",  32'h7FFFFFFF, 1'b1, 1'b0);
    drive(C_AND,  32'hF0F0F0F0, 32'hFF00FF00, "and",      32'hF000F000, 1'b0, 1'b0);
    drive(C_OR,   32'hF0F0F0F0, 32'hFF00FF00, "or",       32'hFFF0FFF0, 1'b0, 1'b0);
    drive(C_XOR,  32'hF0F0F0F0, 32'hFF00FF00, "xor",      32'h0FF00FF0, 1'b0, 1'b0);
    drive(C_NOR,  32'hF0F0F0F0, 32'hFF00FF00, "nor",      32'h000F000F, 1'b0, 1'b0);
    drive(C_SLT,  32'hFFFFFFFF, 32'h1,        "slt",      32'h00000001, 1'b0, 1'b0);
    drive(C_SLTU, 32'hFFFFFFFF, 32'h1,        "sltu",     32'h00000000, 1'b0, 1'b0);
    drive(C_SRA,  32'h80000000, 32'h4,        "sra",      32'hF8000000, 1'b0, 1'b0);
    drive(C_SRL,  32'h80000000, 32'h4,        "srl",      32'h08000000, 1'b0, 1'b0);
    drive(C_SLL,  32'h1,        32'h1F,       "sll",      32'h80000000, 1'b0, 1'b0);

    // Reset in the middle of a multiply
    drive(C_MULT, 32'h5, 32'h5, "mult_abort_issue", 32'h0, 1'b0, 1'b0);
    bubble(9);
    #2 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(C_MFLO, 32'h0, 32'h0, "post_reset_lo", 32'h0, 1'b0, 1'b0);
    drive(C_MFHI, 32'h0, 32'h0, "post_reset_hi", 32'h0, 1'b0, 1'b0);

    drive(C_MULT, 32'h2, 32'h3, "mult_2x3_issue", 32'h0, 1'b0, 1'b0);
    read_stall(C_MFLO, "mult_2x3_lo", 33, 32'h0, 32'h6);
    drive(C_MFHI, 32'h0, 32'h0, "mult_2x3_hi", 32'h0, 1'b0, 1'b0);

    drive(C_MULT, 32'hFFFFFFFD, 32'h7, "mult_neg_issue", 32'h0, 1'b0, 1'b0);
    read_stall(C_MFLO, "mult_neg_lo", 33, 32'h6, 32'hFFFFFFEB);
    drive(C_MFHI, 32'h0, 32'h0, "mult_neg_hi", 32'hFFFFFFFF, 1'b0, 1'b0);

    drive(C_DIV, 32'hFFFFFFF9, 32'h2, "div_neg_issue", 32'h0, 1'b0, 1'b0);
    read_stall(C_MFLO, "div_neg_lo", 33, 32'hFFFFFFEB, 32'hFFFFFFFD);
    drive(C_MFHI, 32'h0, 32'h0, "div_neg_hi", 32'hFFFFFFFF, 1'b0, 1'b0);

    drive(C_DIVU, 32'h7, 32'h0, "divu_zero_issue", 32'h0, 1'b0, 1'b0);
    read_stall(C_MFHI, "divu_zero_hi", 33, 32'hFFFFFFFF, 32'h7);
    drive(C_MFLO, 32'h0, 32'h0, "divu_zero_lo", 32'hFFFFFFFF, 1'b0, 1'b0);

    drive(C_DIV, 32'h80000000, 32'hFFFFFFFF, "div_min_issue", 32'h0, 1'b0, 1'b0);
    read_stall(C_MFLO, "div_min_lo", 33, 32'hFFFFFFFF, 32'h80000000);
    drive(C_MFHI, 32'h0, 32'h0, "div_min_hi", 32'h0, 1'b0, 1'b0);

    // Single-cycle ops overlap a running multiply; a second MD op stalls
    drive(C_MULT, 32'h00010000, 32'h00030001, "ovl_mult_issue", 32'h0, 1'b0, 1'b0);
    drive(C_ADD, 32'h1,        32'h2,        "ovl_add1", 32'h3,        1'b0, 1'b0);
    drive(C_ADD, 32'h7FFFFFFF, 32'h7FFFFFFF, "ovl_add2", 32'hFFFFFFFE, 1'b1, 1'b0);
    drive(C_ADD, 32'hFFFFFFFF, 32'h1,        "ovl_add3", 32'h0,        1'b0, 1'b0);
    drive(C_ADD, 32'h64,       32'hC8,       "ovl_add4", 32'h12C,      1'b0, 1'b0);
    drive(C_ADD, 32'h80000000, 32'h80000000, "ovl_add5", 32'h0,        1'b1, 1'b0);
    md_stall_issue(C_DIV, 32'h64, 32'h7, "ovl_div_issue", 28);
    read_stall(C_MFLO, "ovl_div_lo", 33, 32'h00010000, 32'hE);
    drive(C_MFHI, 32'h0, 32'h0, "ovl_div_hi", 32'h2, 1'b0, 1'b0);

    bubble(1);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_muldiv.md
# alu_muldiv

Parametrised execute-stage ALU for the 5-stage MIPS core, replacing the single-cycle five-op ALU. It adds XOR, NOR, signed/unsigned compare, and shifts. It also adds an iterative multiply/divide engine with architectural HI/LO registers. The engine runs in the background after issue and requests an EX-stage stall only when a later instruction needs HI/LO or the engine itself.

## Interface
Parameters:
- WIDTH, 32, datapath width; must be a power of two, ≥8
- SHW, $clog2(WIDTH), shift-amount width (derived, not overridden)

Ports:
- clk  in  1  core clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- SrcAE  in  WIDTH  operand A; value operand for shifts
- SrcBE  in  WIDTH  operand B; shift amount = SrcBE[SHW-1:0]
- ALUControlE  in  4  operation select
- ValidE  in  1  EX holds a real instruction (not a bubble)
- ALUOutE  out  WIDTH  result (combinational)
- ZeroE  out  1  ALUOutE == 0
- OverflowE  out  1  signed overflow, ADD/SUB only, else 0
- BusyE  out  1  stall request to hazard unit

## Operation
- Op codes:
  - 0000 AND; 0001 OR; 0010 ADD; 0011 XOR; 0100 NOR; 0101 SLL; 0110 SUB.
  - 0111 SLT (signed); 1000 SLTU; 1001 SRL; 1010 SRA.
  - 1011 MULT (signed); 1100 DIV (signed); 1101 DIVU.
  - 1110 MFHI; 1111 MFLO.
- Single-cycle ops (0000–1010): pure combinational, same cycle; ADD/SUB wrap modulo 2^WIDTH.
- SLT/SLTU: result is zero-extended to WIDTH.
- MFHI/MFLO: ALUOutE = HI / LO register.
- MULT/DIV/DIVU: ALUOutE = 0.
- Issue rule: a MD op issues when ValidE=1, the op is MULT/DIV/DIVU, and the engine is IDLE.
  - Operands are latched; no GPR result.
- Engine FSM:
  - IDLE → CALC on issue.
  - CALC: WIDTH iterations, counter 0..WIDTH-1, on operand magnitudes. Multiply is shift-add; divide is restoring.
  - CALC → FIX when counter = WIDTH-1.
  - FIX → IDLE after one cycle; HI/LO are written at the end of FIX.
- MULT result: 2·WIDTH-bit product, negated if operand signs differ. HI = upper half, LO = lower half.
- DIV results: LO = quotient, HI = remainder.
  - Quotient is negated if operand signs differ.
  - Remainder takes the dividend's sign.
  - DIVU: no sign fix.
- Divide by zero: HI = dividend, LO = all ones; applies to both DIV and DIVU.
- DIV of MIN by −1: LO = MIN, HI = 0; no trap.
- BusyE = ValidE & (op ∈ {MULT, DIV, DIVU, MFHI, MFLO}) & (state ≠ IDLE).
  - Single-cycle ops never stall.
  - A stalled MD op issues in the first IDLE cycle.
- Reset (any time, including mid-CALC/FIX):
  - state=IDLE, counter=0, HI=0, LO=0; the in-flight op is discarded.
  - BusyE=0.
  - ALUOutE, ZeroE and OverflowE follow the inputs combinationally.

## Timing
- Single-cycle ops: latency 0, no stall.
- MD op issued in cycle T:
  - CALC occupies T+1..T+WIDTH; FIX occupies T+WIDTH+1.
  - HI/LO are new from T+WIDTH+2 (cycle 34 for WIDTH=32).
- MFHI/MFLO or a new MD op in T+1..T+WIDTH+1 holds BusyE=1 through T+WIDTH+1. It completes/issues in T+WIDTH+2.
- No HI/LO forwarding from FIX.
- MFHI in cycle T returns the old HI.
- Back-to-back MD issue has a minimum spacing of WIDTH+2 cycles.

## Structure
- Shared package alu_pkg:
  - 4-bit op-code localparams (AND…MFLO), matching the existing encodings for AND/OR/ADD/SUB/SLT.
  - MD FSM state enum (IDLE, CALC, FIX).
- One sub-module: md_unit, containing:
  - issue logic, FSM and counter
  - magnitude/sign handling and the iterative datapath
  - HI/LO registers
- md_unit outputs HI, LO and idle.
- The top level holds the combinational op mux, flag logic and BusyE.

## Test plan
- Reset: assert rst_n=0 at T+10 of a MULT, release → BusyE=0; MFLO returns 0; the next MULT 2×3 gives LO=6 at T'+34.
- Arithmetic flags:
  - ADD 0x7FFFFFFF+1 → 0x80000000, OverflowE=1.
  - SUB 5−5 → 0, ZeroE=1.
  - AND/OR/XOR/NOR of 0xF0F0F0F0 and 0xFF00FF00 → 0xF000F000, 0xFFF0FFF0, 0x0FF00FF0, 0x000F000F.
- Compare/shift:
  - SLT 0xFFFFFFFF vs 1 → 1; SLTU same operands → 0.
  - SRA 0x80000000 by 4 → 0xF8000000; SRL → 0x08000000; SLL 1 by 31 → 0x80000000.
- MULT with stall: MULT −3×7 at T, MFLO at T+1 → BusyE=1 for T+1..T+33; at T+34 MFLO = 0xFFFFFFEB, then MFHI = 0xFFFFFFFF.
- Divide corner cases:
  - DIV −7/2 → LO=0xFFFFFFFD, HI=0xFFFFFFFF.
  - DIVU 7/0 → HI=7, LO=0xFFFFFFFF.
  - DIV 0x80000000/−1 → LO=0x80000000, HI=0.
- Overlap: MULT at T, ADD ops during T+1..T+5 (no stall, correct results), DIV at T+6 → stalls until T+34. DIV issues at T+34; its HI/LO are valid at T+68.
